// File: rtl/sd_bd_fifo_if.sv
// Buffer-descriptor FIFO bus: register-file write stream in, data-master read stream out.
interface sd_bd_fifo_if #(parameter int RAM_MEM_WIDTH = 16) ();
  logic                     we_m_i;
  logic [RAM_MEM_WIDTH-1:0] dat_in_m_i;
  logic [7:0]               free_bd_o;
  logic                     re_s_i;
  logic [RAM_MEM_WIDTH-1:0] dat_out_s_o;
  logic                     dat_out_valid_o;
  logic                     bd_avail_o;
  logic                     overflow_o;
  logic                     underflow_o;

  modport master (
    output we_m_i, dat_in_m_i, re_s_i,
    input  free_bd_o, dat_out_s_o, dat_out_valid_o, bd_avail_o, overflow_o, underflow_o
  );

  modport slave (
    input  we_m_i, dat_in_m_i, re_s_i,
    output free_bd_o, dat_out_s_o, dat_out_valid_o, bd_avail_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/sd_bd_fifo.sv
// Descriptor queue: packs register-file words into BD_SIZE-word descriptors and
// releases committed descriptors word by word to the DMA data master.
module sd_bd_fifo #(
  parameter int RAM_MEM_WIDTH = 16,
  parameter int BD_SIZE       = 4,
  parameter int BD_NUM        = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        clear_i,
  sd_bd_fifo_if.slave bus
);
  localparam int DEPTH = BD_NUM * BD_SIZE;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (BD_SIZE > 1) ? $clog2(BD_SIZE) : 1;

  logic [RAM_MEM_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            wr_cnt, rd_cnt;
  logic [7:0]               bd_cnt, free_bd, bd_cnt_nxt, free_bd_nxt;
  logic [RAM_MEM_WIDTH-1:0] dat_out;
  logic                     dat_vld, bd_avail, ovf, udf;
  logic                     wr_ok, rd_ok, commit, rel;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // free_bd only drops on commit, so a started descriptor always has room to finish
  assign wr_ok  = bus.we_m_i && (free_bd != 8'd0);
  assign rd_ok  = bus.re_s_i && (bd_cnt != 8'd0);
  assign commit = wr_ok && (wr_cnt == CW'(BD_SIZE - 1));
  assign rel    = rd_ok && (rd_cnt == CW'(BD_SIZE - 1));

  always_comb begin
    bd_cnt_nxt  = bd_cnt;
    free_bd_nxt = free_bd;
    case ({commit, rel})
      2'b10: begin bd_cnt_nxt = bd_cnt + 8'd1; free_bd_nxt = free_bd - 8'd1; end
      2'b01: begin bd_cnt_nxt = bd_cnt - 8'd1; free_bd_nxt = free_bd + 8'd1; end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i || clear_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      bd_cnt   <= 8'd0;
      free_bd  <= 8'(BD_NUM);
      bd_avail <= 1'b0;
      dat_out  <= '0;
      dat_vld  <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
        wr_cnt <= commit ? '0 : wr_cnt + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr  <= ptr_inc(rd_ptr);
        rd_cnt  <= rel ? '0 : rd_cnt + 1'b1;
        dat_out <= mem[rd_ptr];
      end
      bd_cnt   <= bd_cnt_nxt;
      free_bd  <= free_bd_nxt;
      bd_avail <= (bd_cnt_nxt != 8'd0);
      dat_vld  <= rd_ok;
      ovf      <= bus.we_m_i && !wr_ok;
      udf      <= bus.re_s_i && !rd_ok;
    end
  end

  // Storage needs no reset; reads only ever reach committed words
  always_ff @(posedge wb_clk_i) begin
    if (wr_ok) mem[wr_ptr] <= bus.dat_in_m_i;
  end

  assign bus.free_bd_o       = free_bd;
  assign bus.bd_avail_o      = bd_avail;
  assign bus.dat_out_s_o     = dat_out;
  assign bus.dat_out_valid_o = dat_vld;
  assign bus.overflow_o      = ovf;
  assign bus.underflow_o     = udf;
endmodule
